// File: rtl/comp_tally_if.sv
// Handshake bundle between the comparator front end and comp_tally.
// Strobed comparator decisions go in; scores and match status come out.
interface comp_tally_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             sample;
    logic [1:0]       comp_out;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [CNT_W-1:0] cnt_tie;
    logic [1:0]       leader;
    logic [1:0]       winner;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, sample, comp_out,
        input  cnt1, cnt2, cnt_tie,
        input  leader, winner,
        input  busy, done, err
    );

    modport slave (
        input  start, sample, comp_out,
        output cnt1, cnt2, cnt_tie,
        output leader, winner,
        output busy, done, err
    );
endinterface

// File: rtl/comp_tally.sv
// Match-scoring counter behind the magnitude comparator.
// Tallies side wins and ties; first side to WIN_TARGET ends the match.
module comp_tally #(
    parameter int CNT_W      = 4,
    parameter int WIN_TARGET = 7
) (
    input logic         clk,
    input logic         rst,
    comp_tally_if.slave tally
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TGT  = CNT_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAXV = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;
    logic [CNT_W-1:0] tie_q, tie_d;
    logic [1:0]       winner_q, winner_d;
    logic             err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        tie_d    = tie_q;
        winner_d = winner_q;
        err_d    = err_q;
        if (tally.start) begin
            state_d  = S_ARMED;
            cnt1_d   = '0;
            cnt2_d   = '0;
            tie_d    = '0;
            winner_d = 2'b00;
            err_d    = 1'b0;
        end else if (state_q == S_ARMED && tally.sample) begin
            unique case (tally.comp_out)
                2'b10: begin
                    cnt1_d = cnt1_q + ONE;
                    // Win is judged on the next-state count.
                    if (cnt1_d == TGT) begin
                        winner_d = 2'b10;
                        state_d  = S_DONE;
                    end
                end
                2'b01: begin
                    cnt2_d = cnt2_q + ONE;
                    if (cnt2_d == TGT) begin
                        winner_d = 2'b01;
                        state_d  = S_DONE;
                    end
                end
                2'b00: begin
                    if (tie_q != MAXV) begin
                        tie_d = tie_q + ONE;
                    end
                end
                2'b11: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            tie_q    <= '0;
            winner_q <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            tie_q    <= tie_d;
            winner_q <= winner_d;
            err_q    <= err_d;
        end
    end

    assign tally.cnt1    = cnt1_q;
    assign tally.cnt2    = cnt2_q;
    assign tally.cnt_tie = tie_q;
    assign tally.winner  = winner_q;
    assign tally.err     = err_q;
    assign tally.busy    = (state_q == S_ARMED);
    assign tally.done    = (state_q == S_DONE);
    assign tally.leader  = (cnt1_q > cnt2_q) ? 2'b10 :
                           (cnt2_q > cnt1_q) ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_comp_tally.sv
// Bench for comp_tally: directed match scenarios plus random samples,
// two instances (4-bit/target 7 and 2-bit/target 3) against a score model.
module tb_comp_tally;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    comp_tally_if #(.CNT_W(4)) ifa ();
    comp_tally_if #(.CNT_W(2)) ifb ();

    comp_tally #(.CNT_W(4), .WIN_TARGET(7)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .tally (ifa.slave)
    );

    comp_tally #(.CNT_W(2), .WIN_TARGET(3)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .tally (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Score model: one slot per instance
    int m1[2], m2[2], mt[2], merr[2], mwin[2], mbusy[2], mdone[2];
    int tgt[2]  = '{7, 3};
    int tmax[2] = '{15, 3};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m1[k] = 0; m2[k] = 0; mt[k] = 0; merr[k] = 0;
            mwin[k] = 0; mbusy[k] = 0; mdone[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic st,
                              input logic smp, input logic [1:0] code);
        if (st) begin
            m1[k] = 0; m2[k] = 0; mt[k] = 0; merr[k] = 0;
            mwin[k] = 0; mbusy[k] = 1; mdone[k] = 0;
        end else if (mbusy[k] == 1 && smp) begin
            if (code == 2'b10) begin
                m1[k]++;
                if (m1[k] == tgt[k]) begin
                    mwin[k] = 2; mbusy[k] = 0; mdone[k] = 1;
                end
            end else if (code == 2'b01) begin
                m2[k]++;
                if (m2[k] == tgt[k]) begin
                    mwin[k] = 1; mbusy[k] = 0; mdone[k] = 1;
                end
            end else if (code == 2'b00) begin
                if (mt[k] < tmax[k]) mt[k]++;
            end else begin
                merr[k] = 1;
            end
        end
    endtask

    function automatic int lead(input int k);
        if (m1[k] > m2[k]) return 2;
        if (m2[k] > m1[k]) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_cnt1",   32'(ifa.cnt1),    m1[0]);
        chk("a_cnt2",   32'(ifa.cnt2),    m2[0]);
        chk("a_tie",    32'(ifa.cnt_tie), mt[0]);
        chk("a_leader", 32'(ifa.leader),  lead(0));
        chk("a_winner", 32'(ifa.winner),  mwin[0]);
        chk("a_busy",   32'(ifa.busy),    mbusy[0]);
        chk("a_done",   32'(ifa.done),    mdone[0]);
        chk("a_err",    32'(ifa.err),     merr[0]);
        chk("b_cnt1",   32'(ifb.cnt1),    m1[1]);
        chk("b_cnt2",   32'(ifb.cnt2),    m2[1]);
        chk("b_tie",    32'(ifb.cnt_tie), mt[1]);
        chk("b_leader", 32'(ifb.leader),  lead(1));
        chk("b_winner", 32'(ifb.winner),  mwin[1]);
        chk("b_busy",   32'(ifb.busy),    mbusy[1]);
        chk("b_done",   32'(ifb.done),    mdone[1]);
        chk("b_err",    32'(ifb.err),     merr[1]);
    endtask

    task automatic idle_inputs();
        ifa.start = 1'b0; ifa.sample = 1'b0; ifa.comp_out = 2'b00;
        ifb.start = 1'b0; ifb.sample = 1'b0; ifb.comp_out = 2'b00;
    endtask

    task automatic drv_a(input logic st, input logic smp, input logic [1:0] c);
        ifa.start = st; ifa.sample = smp; ifa.comp_out = c;
    endtask

    task automatic drv_b(input logic st, input logic smp, input logic [1:0] c);
        ifb.start = st; ifb.sample = smp; ifb.comp_out = c;
    endtask

    // Inputs are applied at a negedge before calling tick
    task automatic tick();
        @(posedge clk);
        #1;
        model_step(0, ifa.start, ifa.sample, ifa.comp_out);
        model_step(1, ifb.start, ifb.sample, ifb.comp_out);
        check_all();
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // seven side-1 wins, then one extra
        drv_a(1, 0, 2'b00); tick();
        for (int i = 1; i <= 7; i++) begin
            drv_a(0, 1, 2'b10); tick();
            chk("seq_cnt1", 32'(ifa.cnt1), i);
        end
        chk("win1_done",   32'(ifa.done),   1);
        chk("win1_winner", 32'(ifa.winner), 2);
        chk("win1_busy",   32'(ifa.busy),   0);
        drv_a(0, 1, 2'b10); tick();
        chk("win1_hold", 32'(ifa.cnt1), 7);

        // alternating 01/10/00, then one more 01
        drv_a(1, 0, 2'b00); tick();
        for (int i = 0; i < 6; i++) begin
            drv_a(0, 1, 2'b01); tick();
            drv_a(0, 1, 2'b10); tick();
            drv_a(0, 1, 2'b00); tick();
        end
        chk("alt_cnt1",   32'(ifa.cnt1),    6);
        chk("alt_cnt2",   32'(ifa.cnt2),    6);
        chk("alt_tie",    32'(ifa.cnt_tie), 6);
        chk("alt_leader", 32'(ifa.leader),  0);
        drv_a(0, 1, 2'b01); tick();
        chk("win2_cnt2",   32'(ifa.cnt2),   7);
        chk("win2_winner", 32'(ifa.winner), 1);
        chk("win2_done",   32'(ifa.done),   1);

        // illegal code sets sticky err
        drv_a(1, 0, 2'b00); tick();
        drv_a(0, 1, 2'b10); tick();
        drv_a(0, 1, 2'b01); tick();
        drv_a(0, 1, 2'b11); tick();
        chk("err_set",  32'(ifa.err),  1);
        chk("err_cnt1", 32'(ifa.cnt1), 1);
        chk("err_cnt2", 32'(ifa.cnt2), 1);
        drv_a(0, 1, 2'b00); tick();
        drv_a(0, 1, 2'b10); tick();
        chk("err_sticky", 32'(ifa.err), 1);
        drv_a(1, 0, 2'b00); tick();
        chk("err_clear", 32'(ifa.err), 0);

        // start beats a same-cycle sample
        drv_a(0, 1, 2'b10); tick();
        drv_a(1, 1, 2'b10); tick();
        chk("prio_cnt1", 32'(ifa.cnt1), 0);
        chk("prio_busy", 32'(ifa.busy), 1);

        // narrow instance: tie saturation
        drv_b(1, 0, 2'b00); tick();
        for (int i = 1; i <= 5; i++) begin
            drv_b(0, 1, 2'b00); tick();
            chk("sat_tie",  32'(ifb.cnt_tie), (i < 3) ? i : 3);
            chk("sat_done", 32'(ifb.done), 0);
        end

        // async reset mid-match with cnt1=4
        drv_a(1, 0, 2'b00); tick();
        for (int i = 0; i < 4; i++) begin
            drv_a(0, 1, 2'b10); tick();
        end
        chk("pre_rst_cnt1", 32'(ifa.cnt1), 4);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_cnt1",   32'(ifa.cnt1),    0);
        chk("arst_busy",   32'(ifa.busy),    0);
        chk("arst_leader", 32'(ifa.leader),  0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // random matches on both instances
        for (int i = 0; i < 600; i++) begin
            drv_a(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)));
            drv_b(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/comp_tally.md
# comp_tally

Parametrised match-scoring counter that sits behind the two-input magnitude comparator and tallies its decisions over a match. Each strobed comparator result increments the win counter of side 1, side 2 or the tie counter. A small FSM arms a match, declares the first side to reach a programmable target the winner, and freezes the score until a new match is started.

## Interface
- CNT_W, default 4: width of each score counter. Legal range 2..16.
- WIN_TARGET, default 7: wins needed to end the match. Legal range 1..2^CNT_W-1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: clear all counters and arm a new match.
- sample  in  1  qualifies comp_out for the current cycle.
- comp_out  in  2  comparator decision:
  - 2'b10: side 1 wins.
  - 2'b01: side 2 wins.
  - 2'b00: equal, counted as a tie.
  - 2'b11: illegal.
- cnt1  out  CNT_W  side-1 win count.
- cnt2  out  CNT_W  side-2 win count.
- cnt_tie  out  CNT_W  tie count.
- leader  out  2  2'b10 if cnt1>cnt2, 2'b01 if cnt2>cnt1, 2'b00 if equal.
- winner  out  2  2'b10 if side 1 won, 2'b01 if side 2 won, 2'b00 if there is no winner yet.
- busy  out  1  high while a match is in progress (ARMED).
- done  out  1  high while in DONE.
- err  out  1  sticky: an illegal code was sampled during the match.

## Operation
- FSM states: IDLE, ARMED, DONE. Reset state is IDLE.
- Transitions:
  - IDLE -> ARMED on start.
  - ARMED -> DONE when an accepted sample brings cnt1 or cnt2 to WIN_TARGET.
  - DONE -> ARMED on start.
  - ARMED -> ARMED on start: the match restarts.
- start, in any state:
  - Clears cnt1, cnt2, cnt_tie, winner and err on the next edge.
  - Enters ARMED.
  - Has priority over a sample in the same cycle; that sample is discarded.
- An accepted sample is sample=1 while in ARMED, with start=0. On an accepted sample:
  - 10: cnt1 increments.
  - 01: cnt2 increments.
  - 00: cnt_tie increments.
  - 11: no counter changes and err is set.
- Samples in IDLE or DONE are ignored. No counters change and err is not set.
- cnt_tie saturates at 2^CNT_W-1 and does not wrap.
- cnt1 and cnt2 cannot exceed WIN_TARGET, because the match ends when either reaches it.
- Win detection compares the next-state count against WIN_TARGET. On the edge where a count becomes WIN_TARGET:
  - winner is set to that side's code.
  - The state moves to DONE.
  - Both happen on the same edge.
- leader is combinational from the cnt1/cnt2 registers.
- err stays high until the next start or rst.

## Timing
- Reset values: state=IDLE, cnt1=cnt2=cnt_tie=0, leader=00, winner=00, busy=0, done=0, err=0.
- rst is asynchronous. Asserting it mid-match forces all outputs to their reset values immediately, with no clock edge needed.
- Latency from an accepted sample at edge N:
  - The counter shows the new value after edge N.
  - leader updates in the same cycle as that counter.
  - winner and done assert after edge N when that sample is the winning one.
- Latency from start at edge N: busy=1 and all counters read 0 after edge N.
- busy and done are decoded from the state register. They are never high together.
- A sample is accepted every cycle if offered; no back-pressure.

## Test plan
- Reset then start, then seven 10 samples on consecutive cycles (WIN_TARGET=7):
  - cnt1 steps 1..7.
  - After the 7th edge: done=1, winner=10, busy=0.
  - An 8th 10 sample leaves cnt1=7.
- Alternating 01/10/00 samples, 6 of each, then one more 01:
  - After the 18 samples: cnt1=6, cnt2=6, cnt_tie=6, leader=00.
  - After the extra 01: cnt2=7, winner=01, done=1.
- Sample 11 mid-match:
  - err=1 and the counters are unchanged.
  - err remains 1 through further samples.
  - err clears after start.
- start and sample=1 with comp_out=10 in the same cycle during ARMED: cnt1=0 after the edge and busy=1.
- CNT_W=2, WIN_TARGET=3, then five 00 samples:
  - cnt_tie reads 1, 2, 3, 3, 3.
  - done stays 0.
- Mid-match with cnt1=4: assert rst between clock edges. All outputs read reset values before the next edge.
